// File: rtl/sram_controller.sv
// Word-to-halfword bridge between the EXE/MEM stage and a 16-bit asynchronous SRAM.
// Each 32-bit access is split into a low then a high halfword phase while ready stalls the pipeline.
module sram_controller #(
   parameter int BASE_ADDR     = 1024,
   parameter int SRAM_AW       = 18,
   parameter int ACCESS_CYCLES = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic               rd_en,
   input  logic [31:0]        address,
   input  logic [31:0]        write_data,
   output logic [31:0]        read_data,
   output logic               ready,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [15:0]        sram_dq_out,
   input  logic [15:0]        sram_dq_in,
   output logic               sram_dq_oe,
   output logic               sram_we_n
);

   localparam int CW = (ACCESS_CYCLES > 2) ? $clog2(ACCESS_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(ACCESS_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

   state_t             state;
   state_t             state_next;
   logic [CW-1:0]      count;
   logic [CW-1:0]      count_next;
   logic [SRAM_AW-2:0] index_q;
   logic [31:0]        wdata_q;
   logic               write_q;
   logic               request;
   logic               phase_last;
   logic [31:0]        offset;
   logic               unused_offset_bits;

   assign request    = wr_en | rd_en;
   assign phase_last = (count == LAST);

   // Subtraction wraps in 32 bits, so addresses below the base land at the top of the SRAM.
   assign offset             = address - 32'(BASE_ADDR);
   assign unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         count     <= '0;
         index_q   <= '0;
         wdata_q   <= '0;
         write_q   <= 1'b0;
         read_data <= '0;
      end else begin
         state <= state_next;
         count <= count_next;
         if (state == IDLE && request) begin
            index_q <= offset[SRAM_AW:2];
            wdata_q <= write_data;
            write_q <= wr_en;
         end
         // Read data is captured on the final cycle of each phase, after the SRAM has settled.
         if (!write_q && phase_last) begin
            if (state == LOW) begin
               read_data[15:0] <= sram_dq_in;
            end else if (state == HIGH) begin
               read_data[31:16] <= sram_dq_in;
            end
         end
      end
   end

   always_comb begin
      state_next = state;
      count_next = count;
      case (state)
         IDLE: begin
            if (request) begin
               state_next = LOW;
               count_next = '0;
            end
         end
         LOW: begin
            if (phase_last) begin
               state_next = HIGH;
               count_next = '0;
            end else begin
               count_next = count + CW'(1);
            end
         end
         HIGH: begin
            if (phase_last) begin
               state_next = DONE;
               count_next = '0;
            end else begin
               count_next = count + CW'(1);
            end
         end
         DONE: begin
            state_next = IDLE;
            count_next = '0;
         end
         default: begin
            state_next = IDLE;
            count_next = '0;
         end
      endcase
   end

   // The strobe rises on the last phase cycle so address and data are held past its rising edge.
   always_comb begin
      sram_addr   = '0;
      sram_dq_out = '0;
      sram_dq_oe  = 1'b0;
      sram_we_n   = 1'b1;
      case (state)
         LOW: begin
            sram_addr = {index_q, 1'b0};
            if (write_q) begin
               sram_dq_oe  = 1'b1;
               sram_dq_out = wdata_q[15:0];
               sram_we_n   = phase_last;
            end
         end
         HIGH: begin
            sram_addr = {index_q, 1'b1};
            if (write_q) begin
               sram_dq_oe  = 1'b1;
               sram_dq_out = wdata_q[31:16];
               sram_we_n   = phase_last;
            end
         end
         default: begin
            sram_addr = '0;
         end
      endcase
   end

   assign ready = (state == IDLE && !request) || (state == DONE);

endmodule
